// File: rtl/i2c_csr_slave_if.sv
// i2c_csr_slave_if: I2C pin and CSR-port bundle between the I2C target and its bus/CSR neighbours.
interface i2c_csr_slave_if;
    logic       scl;
    logic       sda;
    logic       sda_out;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    modport slave (input scl, sda, csr_di, output sda_out, csr_a, csr_we, csr_do);
    modport master (output scl, sda, csr_di, input sda_out, csr_a, csr_we, csr_do);
endinterface

// File: rtl/i2c_csr_slave.sv
// i2c_csr_slave: I2C target bridging the bus to a 32 x 8-bit CSR space with an auto-incrementing pointer.
module i2c_csr_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h4a
) (
    input logic clk,
    input logic rst,
    i2c_csr_slave_if.slave bus
);
    localparam logic [3:0] S_IDLE     = 4'd0,
                           S_ADDR     = 4'd1,
                           S_ACK_ADDR = 4'd2,
                           S_WR_PTR   = 4'd3,
                           S_ACK_PTR  = 4'd4,
                           S_WR_DATA  = 4'd5,
                           S_ACK_WR   = 4'd6,
                           S_RD_DATA  = 4'd7,
                           S_RD_ACK   = 4'd8,
                           S_IGNORE   = 4'd9;
    logic [1:0] r_scl_s, r_sda_s;
    logic       r_scl_d, r_sda_d;
    logic [3:0] r_state, r_cnt;
    logic [7:0] r_sh, r_do;
    logic [4:0] r_ptr;
    logic       r_ack, r_we, r_sda_out;
    logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_match, w_rd_load;
    assign w_scl     = r_scl_s[1];
    assign w_sda     = r_sda_s[1];
    assign w_rise    = w_scl & ~r_scl_d;
    assign w_fall    = ~w_scl & r_scl_d;
    assign w_start   = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop    = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_match   = r_sh[7:1] == I2C_ADDR;
    // A read byte is fetched at the fall ending the address ACK or a master ACK
    assign w_rd_load = w_fall & ((r_state == S_ACK_ADDR & r_sh[0]) | (r_state == S_RD_ACK & ~r_ack));
    assign bus.sda_out = r_sda_out;
    assign bus.csr_a   = r_ptr;
    assign bus.csr_we  = r_we;
    assign bus.csr_do  = r_do;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s   <= 2'b11;
            r_sda_s   <= 2'b11;
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_sh      <= 8'd0;
            r_do      <= 8'd0;
            r_ptr     <= 5'd0;
            r_ack     <= 1'b1;
            r_we      <= 1'b0;
            r_sda_out <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], bus.scl};
            r_sda_s <= {r_sda_s[0], bus.sda};
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
            r_we    <= 1'b0;
            if (r_we) r_ptr <= r_ptr + 5'd1;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_cnt     <= 4'd0;
                r_sda_out <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_out <= 1'b1;
            end else if (w_rise) begin
                case (r_state)
                    S_ADDR, S_WR_PTR, S_WR_DATA: begin
                        r_sh  <= {r_sh[6:0], w_sda};
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7 && r_state == S_WR_PTR) r_ptr <= {r_sh[3:0], w_sda};
                        if (r_cnt == 4'd7 && r_state == S_WR_DATA) begin
                            r_we <= 1'b1;
                            r_do <= {r_sh[6:0], w_sda};
                        end
                    end
                    S_RD_DATA: r_cnt <= r_cnt + 4'd1;
                    S_RD_ACK:  r_ack <= w_sda;
                    default: ;
                endcase
            end else if (w_rd_load) begin
                r_sh      <= bus.csr_di;
                r_sda_out <= bus.csr_di[7];
                r_ptr     <= r_ptr + 5'd1;
                r_cnt     <= 4'd0;
                r_state   <= S_RD_DATA;
            end else if (w_fall) begin
                case (r_state)
                    S_ADDR: if (r_cnt == 4'd8) begin
                        r_state   <= w_match ? S_ACK_ADDR : S_IGNORE;
                        r_sda_out <= ~w_match;
                    end
                    S_WR_PTR: if (r_cnt == 4'd8) begin
                        r_state   <= S_ACK_PTR;
                        r_sda_out <= 1'b0;
                    end
                    S_WR_DATA: if (r_cnt == 4'd8) begin
                        r_state   <= S_ACK_WR;
                        r_sda_out <= 1'b0;
                    end
                    S_ACK_ADDR: begin
                        r_state   <= S_WR_PTR;
                        r_cnt     <= 4'd0;
                        r_sda_out <= 1'b1;
                    end
                    S_ACK_PTR, S_ACK_WR: begin
                        r_state   <= S_WR_DATA;
                        r_cnt     <= 4'd0;
                        r_sda_out <= 1'b1;
                    end
                    S_RD_DATA: begin
                        r_state   <= (r_cnt == 4'd8) ? S_RD_ACK : S_RD_DATA;
                        r_sda_out <= (r_cnt == 4'd8) ? 1'b1 : r_sh[6];
                        r_sh      <= {r_sh[6:0], 1'b0};
                    end
                    S_RD_ACK: begin
                        r_state   <= S_IGNORE;
                        r_sda_out <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_csr_slave.sv
// tb_i2c_csr_slave: directed I2C master driving the CSR target, with a CSR memory model and strobe monitor.
module tb_i2c_csr_slave;
    localparam int Q = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic use_mem = 1'b0;
    logic [7:0] fix_di = 8'h00;
    logic [7:0] mem [32];
    logic [12:0] we_log [$];
    logic we_q = 1'b0, we_wide = 1'b0, mon_low = 1'b0, low_seen = 1'b0;
    int ncmp = 0, nfail = 0;
    i2c_csr_slave_if bus();
    assign bus.scl    = m_scl;
    assign bus.sda    = m_sda & bus.sda_out;
    assign bus.csr_di = use_mem ? mem[bus.csr_a] : fix_di;
    i2c_csr_slave #(.I2C_ADDR(7'h4a)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.csr_we === 1'b1) begin
            we_log.push_back({bus.csr_a, bus.csr_do});
            mem[bus.csr_a] = bus.csr_do;
            if (we_q) we_wide = 1'b1;
        end
        we_q = bus.csr_we;
        if (mon_low && bus.sda_out === 1'b0) low_seen = 1'b1;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic i2c_bit(input logic b, output logic r);
        m_sda = b; wt(Q);
        m_scl = 1'b1; wt(Q);
        r = bus.sda; wt(Q);
        m_scl = 1'b0; wt(Q);
    endtask
    task automatic i2c_start();
        m_sda = 1'b1; wt(Q);
        m_scl = 1'b1; wt(Q);
        m_sda = 1'b0; wt(Q);
        m_scl = 1'b0; wt(Q);
    endtask
    task automatic i2c_stop();
        m_sda = 1'b0; wt(Q);
        m_scl = 1'b1; wt(Q);
        m_sda = 1'b1; wt(Q);
    endtask
    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask
    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(mack, r);
    endtask
    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3);
    endfunction
    initial begin
        logic a0, a1, a2, a3, r;
        logic [7:0] d;
        int n0;
        wt(4);
        chk("rst_sda_out", 32'(bus.sda_out), 1);
        chk("rst_csr_we", 32'(bus.csr_we), 0);
        chk("rst_csr_a", 32'(bus.csr_a), 0);
        chk("rst_csr_do", 32'(bus.csr_do), 0);
        rst = 1'b0; wt(4);
        // Write with pointer wrap 0x1f -> 0x00
        i2c_start();
        wr_byte(8'h94, a0); wr_byte(8'h1f, a1); wr_byte(8'haa, a2); wr_byte(8'h55, a3);
        i2c_stop();
        chk("wr_acks", 32'({a0, a1, a2, a3}), 0);
        chk("wr_we_count", we_log.size(), 2);
        chk("wr_we0", 32'(we_log[0]), 32'({5'h1f, 8'haa}));
        chk("wr_we1", 32'(we_log[1]), 32'({5'h00, 8'h55}));
        chk("wr_ptr_after", 32'(bus.csr_a), 1);
        // Wrong address is ignored entirely
        n0 = we_log.size(); low_seen = 1'b0; mon_low = 1'b1;
        i2c_start();
        wr_byte(8'h96, a0); wr_byte(8'h1f, a1); wr_byte(8'haa, a2);
        i2c_stop();
        mon_low = 1'b0;
        chk("nomatch_acks", 32'({a0, a1, a2}), 32'b111);
        chk("nomatch_sda_low", 32'(low_seen), 0);
        chk("nomatch_we", we_log.size(), n0);
        chk("nomatch_ptr", 32'(bus.csr_a), 1);
        // Read burst via repeated START, master NACKs the third byte
        fix_di = 8'h83;
        i2c_start();
        wr_byte(8'h94, a0); wr_byte(8'h10, a1);
        chk("rd_ptr_set", 32'(bus.csr_a), 32'h10);
        i2c_start();
        wr_byte(8'h95, a2);
        chk("rd_acks", 32'({a0, a1, a2}), 0);
        chk("rd_ptr_a0", 32'(bus.csr_a), 32'h11);
        rd_byte(1'b0, d); chk("rd_b0", 32'(d), 32'h83); chk("rd_ptr_a1", 32'(bus.csr_a), 32'h12);
        rd_byte(1'b0, d); chk("rd_b1", 32'(d), 32'h83); chk("rd_ptr_a2", 32'(bus.csr_a), 32'h13);
        rd_byte(1'b1, d); chk("rd_b2", 32'(d), 32'h83); chk("rd_ptr_a3", 32'(bus.csr_a), 32'h13);
        rd_byte(1'b1, d); chk("rd_after_nack", 32'(d), 32'hff);
        i2c_stop();
        // STOP mid data byte discards it; next transaction is accepted
        n0 = we_log.size();
        i2c_start();
        wr_byte(8'h94, a0); wr_byte(8'h05, a1);
        for (int i = 0; i < 4; i++) i2c_bit(1'b0, r);
        i2c_stop();
        chk("midstop_we", we_log.size(), n0);
        chk("midstop_ptr", 32'(bus.csr_a), 5);
        i2c_start();
        wr_byte(8'h94, a2); wr_byte(8'h07, a3);
        i2c_stop();
        chk("midstop_acks", 32'({a0, a1, a2, a3}), 0);
        chk("midstop_newptr", 32'(bus.csr_a), 7);
        // Reset while the target holds SDA low during a read
        fix_di = 8'h00;
        i2c_start();
        wr_byte(8'h94, a0); wr_byte(8'h08, a1);
        i2c_start();
        wr_byte(8'h95, a2);
        chk("rstrd_sda_low", 32'(bus.sda_out), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstrd_sda_out", 32'(bus.sda_out), 1);
        chk("rstrd_csr_a", 32'(bus.csr_a), 0);
        chk("rstrd_csr_we", 32'(bus.csr_we), 0);
        @(negedge clk); rst = 1'b0;
        i2c_stop();
        // Pointer sweep: one data byte per pointer value, then read all back
        use_mem = 1'b1;
        for (int i = 0; i < 32; i++) begin
            i2c_start();
            wr_byte(8'h94, a0); wr_byte(8'(i), a1); wr_byte(pat(i), a2);
            i2c_stop();
            chk("sweep_acks", 32'({a0, a1, a2}), 0);
            chk("sweep_we", 32'(we_log[we_log.size() - 1]), 32'({5'(i), pat(i)}));
            chk("sweep_ptr", 32'(bus.csr_a), 32'((i + 1) & 31));
        end
        chk("we_one_clk", 32'(we_wide), 0);
        i2c_start();
        wr_byte(8'h94, a0); wr_byte(8'h1f, a1);
        i2c_start();
        wr_byte(8'h95, a2);
        chk("sweep_rd_acks", 32'({a0, a1, a2}), 0);
        for (int k = 0; k < 32; k++) begin
            rd_byte(k == 31, d);
            chk("sweep_rd_data", 32'(d), 32'(pat((31 + k) & 31)));
            if (k < 31) chk("sweep_rd_ptr", 32'(bus.csr_a), 32'((k + 1) & 31));
        end
        i2c_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
